cmp_share_arb: RTL and testbench
================================

Name: cmp_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one W-bit magnitude comparator between NREQ requesters in the CPU (branch unit, ALU SLT path, address-bound checks).
- Each requester presents an operand pair with a valid/ready handshake and receives a registered lt/eq/gt result with its requester ID.
- Only one transaction is outstanding at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand width.
- IDW, $clog2(NREQ), requester ID width (derived; not user-set).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_a  input  NREQ*W  operand A; requester i occupies [i*W +: W].
- req_b  input  NREQ*W  operand B; same packing.
- resp_valid  output  NREQ  one-hot response valid for the owning requester.
- resp_ready  input  NREQ  per-requester response accept.
- resp_lt  output  1  A < B.
- resp_eq  output  1  A == B.
- resp_gt  output  1  A > B.
- resp_id  output  IDW  ID of the requester owning the current response.
- busy  output  1  high while in RESP.

Behaviour:
- Reset is asynchronous, active-high.
  - State=IDLE, rr_ptr=0.
  - req_ready=0, resp_valid=0, resp_lt/eq/gt=0, resp_id=0, busy=0.
  - Reset mid-transaction discards the captured operands. No response is delivered.
- FSM has two states, IDLE and RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[winner]=1, combinational from req_valid and rr_ptr. All other bits are 0. If no valid, all bits are 0.
  - On the handshake edge (req_valid[w] & req_ready[w]):
    - Register lt/eq/gt from req_a[w], req_b[w].
    - Set resp_id=w and go to RESP.
- RESP:
  - resp_valid[resp_id]=1 and busy=1. req_ready=0 for all requesters.
  - Result and ID are held stable until resp_ready[resp_id]=1. resp_ready bits of other requesters are ignored.
  - On the response handshake: go to IDLE, rr_ptr = (resp_id+1) mod NREQ.
- Latency and throughput:
  - Request accepted at edge T; resp_valid is high from T+1.
  - Minimum period is 2 cycles per transaction: accept, then respond. Back-to-back requests from the same requester are therefore accepted every 2nd cycle at best.
- Comparison is unsigned over W bits. Exactly one of lt/eq/gt is high whenever resp_valid is nonzero.
- Fairness:
  - rr_ptr advances past the served requester only.
  - With all NREQ valid continuously, every requester is served once per NREQ transactions. No starvation.
- rr_ptr wraps from NREQ-1 to 0.
- A requester dropping req_valid before it is granted is legal and causes no state change.
- Operands must be stable only during the handshake cycle.

Optional Feature:
- Macro: CMP_SIGNED_EN.
- When defined:
  - Adds input port req_signed [NREQ].
  - The winner's bit is captured at the handshake.
  - If set, operands compare as two's-complement W-bit values; otherwise unsigned.
- When undefined: the port is absent and all comparisons are unsigned.

Decomposition:
- Shared package cmp_pkg:
  - typedef cmp_state_t {IDLE, RESP}.
  - typedef cmp_res_t struct {lt, eq, gt}.
  - Function rr_pick(valid, ptr) returning the winner index.
- Sub-module cmp_core: purely combinational W-bit comparator producing lt/eq/gt, with a signed select input.
  - The select is tied 0 unless CMP_SIGNED_EN is defined.
  - Instantiated once inside cmp_share_arb.

Test Plan:
- Basic compare:
  - Stimulus: rst pulse; req_valid=0001, A0=16'h003D, B0=16'h003E.
  - Expect: req_ready=0001 for 1 cycle; next cycle resp_valid=0001, lt=1, eq=0, gt=0, resp_id=0.
  - Then resp_ready[0]=1: IDLE, rr_ptr=1.
- Round-robin:
  - Stimulus: req_valid=1111 held, resp_ready=1111.
  - Expect: grant order 0,1,2,3,0.
  - Transaction pairs: A=B=16'h1234 gives eq=1; A=16'hFFFF, B=16'h0001 gives gt=1 (unsigned).
- Response backpressure:
  - Stimulus: resp_ready=0 for 5 cycles, resp_ready[2] pulsed on a non-owner.
  - Expect: resp_valid, lt/eq/gt and resp_id held constant; req_ready=0 throughout; no state change.
- Reset mid-operation:
  - Stimulus: assert rst in RESP, between clock edges.
  - Expect: resp_valid=0, busy=0, lt/eq/gt=0 immediately.
  - After release: rr_ptr=0, and the next grant goes to the lowest valid index.
- Signed compare (only with CMP_SIGNED_EN):
  - Stimulus: A=16'h8000, B=16'h0001.
  - Expect: req_signed=1 gives lt=1; req_signed=0 gives gt=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and round-robin winner selection for the comparator-sharing arbiter.
package cmp_pkg;

    typedef enum logic {IDLE, RESP} cmp_state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_res_t;

    localparam int unsigned RR_MAX = 8;

    // First valid index at or after ptr, wrapping modulo n (n <= RR_MAX).
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            idx = (ptr + k) % n;
            if (k < n && !found && valid[idx[2:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational W-bit magnitude comparator; sgn selects two's-complement ordering.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sgn,
    output cmp_res_t     res
);

    logic lt_u;
    logic lt_s;

    always_comb begin
        lt_u   = a < b;
        lt_s   = $signed(a) < $signed(b);
        res.eq = a == b;
        res.lt = sgn ? lt_s : lt_u;
        res.gt = !res.eq && !res.lt;
    end

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one comparator among NREQ requesters, one transaction in flight.
// Optional CMP_SIGNED_EN adds a per-requester req_signed input for two's-complement compares.
module cmp_share_arb
    import cmp_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    parameter  int unsigned W    = 16,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CMP_SIGNED_EN
    input  logic [NREQ-1:0]   req_signed,
`endif
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic              resp_lt,
    output logic              resp_eq,
    output logic              resp_gt,
    output logic [IDW-1:0]    resp_id,
    output logic              busy
);

    cmp_state_t      state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  winner;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic            sgn_sel;
    cmp_res_t        cmp_now;
    cmp_res_t        res_q;

    always_comb begin
        winner = IDW'(rr_pick(8'(req_valid), 32'(rr_ptr), NREQ));
        grant  = NREQ'(1) << winner;
        a_sel  = req_a[32'(winner)*W +: W];
        b_sel  = req_b[32'(winner)*W +: W];
`ifdef CMP_SIGNED_EN
        sgn_sel = req_signed[winner];
`else
        sgn_sel = 1'b0;
`endif
        req_ready = (state == IDLE && |req_valid) ? grant : '0;
    end

    cmp_core #(.W(W)) u_core (
        .a   (a_sel),
        .b   (b_sel),
        .sgn (sgn_sel),
        .res (cmp_now)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            res_q      <= '0;
            resp_id    <= '0;
            resp_valid <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        res_q      <= cmp_now;
                        resp_id    <= winner;
                        resp_valid <= grant;
                        busy       <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[resp_id]) begin
                        rr_ptr     <= (resp_id == IDW'(NREQ - 1)) ? '0 : resp_id + 1'b1;
                        res_q      <= '0;
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resp_lt = res_q.lt;
    assign resp_eq = res_q.eq;
    assign resp_gt = res_q.gt;

endmodule

// File: tb/tb_cmp_share_arb.sv
// Scoreboard bench for cmp_share_arb: directed stimulus pushes expected responses, a monitor pops them.
module tb_cmp_share_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_signed;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic              resp_lt;
    logic              resp_eq;
    logic              resp_gt;
    logic [1:0]        resp_id;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // expected {resp_valid, resp_id, lt, eq, gt}
    logic [NREQ+4:0] sb_q[$];

    cmp_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CMP_SIGNED_EN
        .req_signed (req_signed),
`endif
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_lt    (resp_lt),
        .resp_eq    (resp_eq),
        .resp_gt    (resp_gt),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic lt, input logic eq, input logic gt);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << id;
        sb_q.push_back({oh, 2'(id), lt, eq, gt});
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Compares each response at the cycle its owner accepts it.
    always @(negedge clk) begin
        if (!rst && resp_valid != '0 && (resp_valid & resp_ready) != '0) begin
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", 32'({resp_valid, resp_id, resp_lt, resp_eq, resp_gt}), 32'h0);
            end else begin
                chk("resp", 32'({resp_valid, resp_id, resp_lt, resp_eq, resp_gt}), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int guard;
        logic [NREQ-1:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst = 1'b1; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0; req_signed = '0;
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_flags", 32'({busy, resp_lt, resp_eq, resp_gt, resp_id}), 32'h0);
        rst = 1'b0;

        // Basic compare: 0x003D < 0x003E
        set_ops(0, 16'h003D, 16'h003E);
        req_valid = 4'b0001;
        push(0, 1, 0, 0);
        #1 chk("basic_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("basic_ready_resp", 32'(req_ready), 32'h0);
        chk("basic_busy", 32'(busy), 32'h1);
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        chk("basic_idle", 32'({busy, resp_valid}), 32'h0);
        req_valid = 4'b0011;
        #1 chk("ptr_after_basic", 32'(req_ready), 32'h2);
        req_valid = '0;

        // Fresh reset, then round-robin with all requesters valid
        rst = 1'b1; tick(); rst = 1'b0;
        set_ops(0, 16'h1234, 16'h1234);
        set_ops(1, 16'hFFFF, 16'h0001);
        set_ops(2, 16'h1234, 16'h1234);
        set_ops(3, 16'hFFFF, 16'h0001);
        push(0, 0, 1, 0); push(1, 0, 0, 1); push(2, 0, 1, 0); push(3, 0, 0, 1); push(0, 0, 1, 0);
        resp_ready = 4'b1111;
        req_valid  = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1 chk("rr_grant", 32'(req_ready), 32'(order[g]));
            tick();
            if (g == 4) req_valid = '0;
            chk("rr_resp_valid", 32'(resp_valid), 32'(order[g]));
            tick();
        end
        resp_ready = '0;

        // Backpressure: owner 1 holds while requester 2's ready pulses (ptr now 1)
        set_ops(1, 16'h0100, 16'h00FF);
        req_valid = 4'b0110;
        push(1, 0, 0, 1);
        #1 chk("bp_grant", 32'(req_ready), 32'h2);
        tick();
        for (int c = 0; c < 5; c++) begin
            resp_ready = (c == 2) ? 4'b0100 : 4'b0000;
            chk("bp_hold", 32'({resp_valid, resp_id, resp_lt, resp_eq, resp_gt, busy}), 32'({4'b0010, 2'd1, 3'b001, 1'b1}));
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            tick();
        end
        req_valid  = '0;
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        chk("bp_released", 32'({busy, resp_valid}), 32'h0);

        // Reset mid-transaction discards the response (ptr now 2)
        set_ops(3, 16'h0001, 16'h0001);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        chk("mid_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1 chk("mid_rst_outs", 32'({resp_valid, busy, resp_lt, resp_eq, resp_gt, resp_id}), 32'h0);
        tick();
        #3 rst = 1'b0;
        set_ops(2, 16'h0000, 16'hFFFF);
        req_valid = 4'b1100;
        push(2, 1, 0, 0);
        #1 chk("post_rst_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid  = '0;
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
        req_valid  = 4'b1001;
        #1 chk("ptr_wrap_next", 32'(req_ready), 32'h8);
        req_valid  = '0;

        // Sign boundary: 0x8000 vs 0x0001
        set_ops(0, 16'h8000, 16'h0001);
        set_ops(3, 16'h8000, 16'h0001);
`ifdef CMP_SIGNED_EN
        req_signed = 4'b1000;
        req_valid  = 4'b1000;
        push(3, 1, 0, 0);
        tick();
        req_valid  = '0; req_signed = '0;
        resp_ready = 4'b1000;
        tick();
        resp_ready = '0;
`endif
        req_valid = 4'b0001;
        push(0, 0, 0, 1);
        tick();
        req_valid  = '0;
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;

        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
